// File: rtl/seq_signed_divider_pkg.sv
// Shared types and constants for the sequential signed divider.
package seq_signed_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DEF_DATA_WIDTH = 16;

  function automatic int cnt_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

  localparam int DEF_CNT_WIDTH = cnt_width(DEF_DATA_WIDTH);

  localparam logic [DEF_DATA_WIDTH-1:0] DEF_MAX = {1'b0, {(DEF_DATA_WIDTH-1){1'b1}}};
  localparam logic [DEF_DATA_WIDTH-1:0] DEF_MIN = {1'b1, {(DEF_DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/seq_signed_divider_div_sub_step.sv
// One restoring-division trial subtraction on DATA_WIDTH+1 bits.
module seq_signed_divider_div_sub_step
  import seq_signed_divider_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH:0]   minuend_i,
  input  logic [DATA_WIDTH:0]   subtrahend_i,
  output logic [DATA_WIDTH-1:0] diff_o,
  output logic                  nonneg_o
);

  logic [DATA_WIDTH:0] diff_full_s;

  assign diff_full_s = minuend_i - subtrahend_i;
  assign diff_o      = diff_full_s[DATA_WIDTH-1:0];
  assign nonneg_o    = ~diff_full_s[DATA_WIDTH];

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed restoring divider with valid/ready on both sides.
// Quotient truncates toward zero; remainder takes the dividend's sign.
module seq_signed_divider
  import seq_signed_divider_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int CW = cnt_width(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MAX_VAL  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_VAL  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ZERO_VAL = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ONES_VAL = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] ONE_VAL  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]         CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]         CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]         CNT_INIT = CW'(DATA_WIDTH);

  function automatic logic [DATA_WIDTH-1:0] cond_neg(input logic [DATA_WIDTH-1:0] v,
                                                     input logic neg);
    return neg ? (~v + ONE_VAL) : v;
  endfunction

  div_state_e            state_q;
  logic [DATA_WIDTH-1:0] dvd_q;      // |dividend|, becomes the quotient magnitude
  logic [DATA_WIDTH-1:0] dvs_q;
  logic [DATA_WIDTH-1:0] prem_q;
  logic [CW-1:0]         cnt_q;
  logic                  qneg_q;
  logic                  rneg_q;
  logic                  dbz_pend_q;
  logic                  ovf_pend_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] quot_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic                  dbz_q;
  logic                  ovf_q;

  logic [DATA_WIDTH-1:0] dividend_abs_s;
  logic [DATA_WIDTH-1:0] divisor_abs_s;
  logic                  is_dbz_s;
  logic                  is_ovf_s;
  logic [DATA_WIDTH:0]   shifted_s;
  logic [DATA_WIDTH-1:0] diff_s;
  logic                  nonneg_s;
  logic [DATA_WIDTH-1:0] prem_d;
  logic [DATA_WIDTH-1:0] dvd_d;
  logic [CW-1:0]         cnt_d;

  assign dividend_abs_s = cond_neg(dividend, dividend[DATA_WIDTH-1]);
  assign divisor_abs_s  = cond_neg(divisor, divisor[DATA_WIDTH-1]);
  assign is_dbz_s       = (divisor == ZERO_VAL);
  assign is_ovf_s       = (dividend == MIN_VAL) && (divisor == ONES_VAL);
  assign shifted_s      = {prem_q, dvd_q[DATA_WIDTH-1]};

  seq_signed_divider_div_sub_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sub_step (
    .minuend_i    (shifted_s),
    .subtrahend_i ({1'b0, dvs_q}),
    .diff_o       (diff_s),
    .nonneg_o     (nonneg_s)
  );

  // Next partial remainder, quotient shift and counter for one restoring step.
  always_comb begin
    prem_d = shifted_s[DATA_WIDTH-1:0];
    dvd_d  = {dvd_q[DATA_WIDTH-2:0], nonneg_s};
    cnt_d  = cnt_q - CNT_ONE;
    if (nonneg_s) begin
      prem_d = diff_s;
    end else begin
      prem_d = shifted_s[DATA_WIDTH-1:0];
    end
  end

  // Control FSM and datapath registers, including the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dvd_q       <= ZERO_VAL;
      dvs_q       <= ZERO_VAL;
      prem_q      <= ZERO_VAL;
      cnt_q       <= CNT_ZERO;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      dbz_pend_q  <= 1'b0;
      ovf_pend_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quot_q      <= ZERO_VAL;
      rem_q       <= ZERO_VAL;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            dvd_q      <= dividend_abs_s;
            dvs_q      <= divisor_abs_s;
            prem_q     <= ZERO_VAL;
            cnt_q      <= CNT_INIT;
            qneg_q     <= dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
            rneg_q     <= dividend[DATA_WIDTH-1];
            dbz_pend_q <= is_dbz_s;
            ovf_pend_q <= is_ovf_s;
            in_ready_q <= 1'b0;
            if (is_dbz_s || is_ovf_s) begin
              state_q <= DONE;
            end else begin
              state_q <= CALC;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          if (cnt_q != CNT_ZERO) begin
            prem_q <= prem_d;
            dvd_q  <= dvd_d;
            cnt_q  <= cnt_d;
          end else begin
            quot_q      <= cond_neg(dvd_q, qneg_q);
            rem_q       <= cond_neg(prem_q, rneg_q);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // Special cases arrive here with out_valid low and are resolved in one cycle.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            if (dbz_pend_q) begin
              quot_q <= rneg_q ? MIN_VAL : MAX_VAL;
              rem_q  <= cond_neg(dvd_q, rneg_q);
              dbz_q  <= 1'b1;
            end else begin
              quot_q <= MAX_VAL;
              rem_q  <= ZERO_VAL;
              ovf_q  <= ovf_pend_q;
            end
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          dbz_q       <= 1'b0;
          ovf_q       <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench for seq_signed_divider: directed corners plus random operands.
module tb_seq_signed_divider;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dividend = '0;
  logic [DW-1:0] divisor = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] quotient;
  logic [DW-1:0] remainder;
  logic          div_by_zero;
  logic          overflow;

  seq_signed_divider #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          dbz;
    logic          ovf;
    int            lat;
    int            acc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference: plain integer arithmetic plus the two documented special cases.
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    int   q;
    int   r;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    e.acc = 0;
    if (b == 0) begin
      q = (a >= 0) ? 32767 : -32768;
      r = a;
      e.dbz = 1'b1;
      e.lat = 1;
    end else if (a == -32768 && b == -1) begin
      q = 32767;
      r = 0;
      e.ovf = 1'b1;
      e.lat = 1;
    end else begin
      q = a / b;
      r = a % b;
      e.lat = DW + 1;
    end
    e.q = q[DW-1:0];
    e.r = r[DW-1:0];
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency on out_valid rise, result compare on each handshake.
  logic prev_ov = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_ov = 1'b0;
      end else begin
        if (out_valid && !prev_ov) begin
          if (sb.size() == 0) check("unexpected_valid", {63'd0, out_valid}, 64'd0);
          else check("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
        end
        if (out_valid && out_ready && sb.size() > 0) begin
          e = sb.pop_front();
          check("result", {30'd0, quotient, remainder, div_by_zero, overflow},
                {30'd0, e.q, e.r, e.dbz, e.ovf});
        end
        prev_ov = out_valid;
      end
    end
  end

  task automatic send(input int a, input int b);
    int   g;
    exp_t e;
    g = 0;
    @(negedge clk);
    dividend = a[DW-1:0];
    divisor  = b[DW-1:0];
    in_valid = 1'b1;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e = model(a, b);
    e.acc = cyc;
    sb.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic drain(input bit bp);
    int g;
    g = 0;
    while (sb.size() > 0 && g < 300) begin
      @(negedge clk);
      if (bp) out_ready = ($urandom_range(0, 2) != 0);
      g++;
    end
    @(negedge clk);
    out_ready = 1'b1;
    if (sb.size() > 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic check_reset_vals(input string name);
    check(name, {44'd0, in_ready, out_valid, quotient, remainder, div_by_zero, overflow},
          {44'd0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0});
  endtask

  int dir_a[13] = '{100, -100, 100, -100, 5, -5, -32768, -32768, 0, 32767, -32768, -32768, 0};
  int dir_b[13] = '{7, 7, -7, -7, 0, 0, -1, 1, 5, -32768, -32768, 0, 0};

  initial begin
    logic signed [DW-1:0] ra;
    logic signed [DW-1:0] rb;
    int g;

    repeat (3) @(negedge clk);
    #2;
    check_reset_vals("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      send(dir_a[i], dir_b[i]);
      drain(1'b0);
    end

    // Backpressure: results held in DONE while new operands are offered.
    out_ready = 1'b0;
    send(100, 7);
    g = 0;
    while (!out_valid && g < 40) begin
      @(negedge clk);
      g++;
    end
    check("bp_valid_seen", {63'd0, out_valid}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      dividend = 16'd9;
      divisor  = 16'd2;
      #2;
      check("bp_hold", {30'd0, out_valid, in_ready, quotient, remainder, div_by_zero, overflow},
            {30'd0, 1'b1, 1'b0, 16'd14, 16'd2, 1'b0, 1'b0});
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #2;
    check("consume_cycle_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    #2;
    check("after_consume", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
    send(9, 2);
    drain(1'b0);

    // Asynchronous reset in the middle of a calculation.
    send(1000, 3);
    repeat (6) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    check("in_ready_after_reset", {63'd0, in_ready}, 64'd1);
    send(32767, 3);
    drain(1'b0);

    for (int i = 0; i < 250; i++) begin
      ra = DW'($urandom);
      rb = DW'($urandom);
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: begin ra = 16'sh8000; rb = -16'sd1; end
        2: rb = DW'($urandom_range(0, 8)) - 16'sd4;
        3: ra = 16'sh8000;
        4: rb = 16'sh8000;
        default: ;
      endcase
      send(int'(ra), int'(rb));
      drain($urandom_range(0, 1) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
